id_ld_scoreboard: RTL and testbench

//  - Parametrised ID/EX pipeline register with per-GPR load-use scoreboard.
//  - Replaces the single-stage ID-vs-load compare; supports loads whose data arrives LD_LAT cycles after issue.
//  - Sits between decode logic and EX stage.
//  - Owns the ld_hazard / issue handshake and the ID/EX payload register.

---
 rtl/id_ld_scoreboard.sv | 108 ++++++++++
 tb/tb_id_ld_scoreboard.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ld_scoreboard.sv
// ID/EX pipeline register with a per-GPR load-use scoreboard for multi-cycle load latency.
// Optional load-stall performance counter enabled by defining ID_PERF_CNT_EN.
module id_ld_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int PAYLOAD_W  = 80,
  parameter int LD_LAT     = 1,
  parameter int CNT_W      = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [REG_ADDR_W-1:0] in_ra_addr,
  input  logic                  in_ra_used,
  input  logic [REG_ADDR_W-1:0] in_rb_addr,
  input  logic                  in_rb_used,
  input  logic [REG_ADDR_W-1:0] in_dst_addr,
  input  logic                  in_gpr_we_,
  input  logic                  in_is_load,
  input  logic [PAYLOAD_W-1:0]  in_payload,
  input  logic                  stall_in,
  input  logic                  flush,
  output logic                  in_ready,
  output logic                  ld_hazard,
  output logic                  out_valid,
  output logic [REG_ADDR_W-1:0] out_dst_addr,
  output logic                  out_gpr_we_,
  output logic                  out_is_load,
  output logic [PAYLOAD_W-1:0]  out_payload,
  output logic [31:0]           ld_stall_cnt
);

  localparam int              NUM_REGS = 1 << REG_ADDR_W;
  localparam logic [CNT_W-1:0] LD_LAT_C = CNT_W'(LD_LAT);

  // cnt[r] != 0 means a load to r is still in flight and r must not be read yet.
  logic [CNT_W-1:0] cnt [NUM_REGS];

  logic ra_busy;
  logic rb_busy;
  logic issue;
  logic ld_set;

  assign ra_busy   = in_ra_used && (cnt[in_ra_addr] != '0);
  assign rb_busy   = in_rb_used && (cnt[in_rb_addr] != '0);
  assign ld_hazard = in_valid && (ra_busy || rb_busy);

  // Handshake: an instruction transfers on a cycle where in_valid and in_ready are both high;
  // in_ready already includes in_valid, so in_ready alone marks the issue cycle.
  assign in_ready = in_valid && !ld_hazard && !stall_in && !flush;
  assign issue    = in_ready;
  assign ld_set   = issue && in_is_load && !in_gpr_we_;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
    end else if (!stall_in) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (ld_set && (in_dst_addr == REG_ADDR_W'(i))) begin
          cnt[i] <= LD_LAT_C;
        end else if (cnt[i] != '0) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end

  // Priority: flush > stall_in > issue > bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_dst_addr <= '0;
      out_gpr_we_  <= 1'b1;
      out_is_load  <= 1'b0;
      out_payload  <= '0;
    end else if (flush) begin
      out_valid   <= 1'b0;
      out_gpr_we_ <= 1'b1;
    end else if (!stall_in) begin
      if (issue) begin
        out_valid    <= 1'b1;
        out_dst_addr <= in_dst_addr;
        out_gpr_we_  <= in_gpr_we_;
        out_is_load  <= in_is_load;
        out_payload  <= in_payload;
      end else begin
        out_valid   <= 1'b0;
        out_gpr_we_ <= 1'b1;
      end
    end
  end

`ifdef ID_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (ld_hazard && !stall_in && !flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign ld_stall_cnt = stall_cnt_q;
`else
  assign ld_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_id_ld_scoreboard.sv
// Bench for id_ld_scoreboard: directed load-use scenarios plus random traffic against a
// ready-time reference model; honours ID_PERF_CNT_EN for the stall counter expectation.
module tb_id_ld_scoreboard;

  localparam int AW     = 5;
  localparam int PW     = 80;
  localparam int LD_LAT = 3;
  localparam int CW     = 3;
`ifdef ID_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          in_valid, in_ra_used, in_rb_used, in_gpr_we_, in_is_load;
  logic [AW-1:0] in_ra_addr, in_rb_addr, in_dst_addr;
  logic [PW-1:0] in_payload;
  logic          stall_in, flush;
  logic          in_ready, ld_hazard, out_valid, out_gpr_we_, out_is_load;
  logic [AW-1:0] out_dst_addr;
  logic [PW-1:0] out_payload;
  logic [31:0]   ld_stall_cnt;

  id_ld_scoreboard #(.REG_ADDR_W(AW), .PAYLOAD_W(PW), .LD_LAT(LD_LAT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ra_addr(in_ra_addr), .in_ra_used(in_ra_used),
    .in_rb_addr(in_rb_addr), .in_rb_used(in_rb_used), .in_dst_addr(in_dst_addr),
    .in_gpr_we_(in_gpr_we_), .in_is_load(in_is_load), .in_payload(in_payload),
    .stall_in(stall_in), .flush(flush), .in_ready(in_ready), .ld_hazard(ld_hazard),
    .out_valid(out_valid), .out_dst_addr(out_dst_addr), .out_gpr_we_(out_gpr_we_),
    .out_is_load(out_is_load), .out_payload(out_payload), .ld_stall_cnt(ld_stall_cnt)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: adv counts non-stalled edges; a register is readable once adv reaches ready_at.
  int            adv;
  int            ready_at [1<<AW];
  logic          e_valid, e_we_, e_ld;
  logic [AW-1:0] e_dst;
  logic [PW-1:0] e_payload;
  logic [31:0]   e_perf;
  logic          obs_hz, obs_rdy;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    adv = 0;
    for (int i = 0; i < (1<<AW); i++) ready_at[i] = 0;
    e_valid = 1'b0; e_we_ = 1'b1; e_ld = 1'b0; e_dst = '0; e_payload = '0; e_perf = '0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".out_valid"}, 128'(out_valid), 128'(e_valid));
    chk({tag, ".out_gpr_we_"}, 128'(out_gpr_we_), 128'(e_we_));
    if (e_valid) begin
      chk({tag, ".out_dst_addr"}, 128'(out_dst_addr), 128'(e_dst));
      chk({tag, ".out_is_load"}, 128'(out_is_load), 128'(e_ld));
      chk({tag, ".out_payload"}, 128'(out_payload), 128'(e_payload));
    end
    chk({tag, ".ld_stall_cnt"}, 128'(ld_stall_cnt), PERF_EN ? 128'(e_perf) : 128'(0));
  endtask

  // driver: set all inputs (called just after a rising edge)
  task automatic drv(input logic v, input int ra, input logic rau, input int rb, input logic rbu,
                     input int dst, input logic we_n, input logic ld, input logic st, input logic fl);
    in_valid = v; in_ra_addr = AW'(ra); in_ra_used = rau; in_rb_addr = AW'(rb); in_rb_used = rbu;
    in_dst_addr = AW'(dst); in_gpr_we_ = we_n; in_is_load = ld; stall_in = st; flush = fl;
    in_payload = PW'({$urandom, $urandom, $urandom});
  endtask

  // one clock: check combinational outputs, advance model, check registered outputs
  task automatic cycle(input string tag);
    logic exp_hz, exp_rdy;
    #2;
    exp_hz  = in_valid && ((in_ra_used && adv < ready_at[in_ra_addr]) ||
                           (in_rb_used && adv < ready_at[in_rb_addr]));
    exp_rdy = in_valid && !exp_hz && !stall_in && !flush;
    chk({tag, ".ld_hazard"}, 128'(ld_hazard), 128'(exp_hz));
    chk({tag, ".in_ready"}, 128'(in_ready), 128'(exp_rdy));
    obs_hz  = ld_hazard;
    obs_rdy = in_ready;
    if (exp_hz && !stall_in && !flush && e_perf != 32'hFFFF_FFFF) e_perf = e_perf + 1;
    if (flush) begin
      e_valid = 1'b0; e_we_ = 1'b1;
    end else if (!stall_in) begin
      if (exp_rdy) begin
        e_valid = 1'b1; e_dst = in_dst_addr; e_we_ = in_gpr_we_; e_ld = in_is_load;
        e_payload = in_payload;
      end else begin
        e_valid = 1'b0; e_we_ = 1'b1;
      end
    end
    if (!stall_in) begin
      adv = adv + 1;
      if (exp_rdy && in_is_load && !in_gpr_we_) ready_at[in_dst_addr] = adv + LD_LAT;
    end
    @(posedge clk);
    #1;
    check_regs(tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drv(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      cycle("idle");
    end
  endtask

  int  hz;
  bit  done;

  initial begin
    model_reset();
    drv(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    reset = 1'b1;
    #12;
    chk("rst.ld_hazard", 128'(ld_hazard), 128'(0));
    chk("rst.in_ready", 128'(in_ready), 128'(0));
    chk("rst.out_dst_addr", 128'(out_dst_addr), 128'(0));
    chk("rst.out_is_load", 128'(out_is_load), 128'(0));
    chk("rst.out_payload", 128'(out_payload), 128'(0));
    check_regs("rst");
    @(posedge clk); #1;
    reset = 1'b0;

    // LDW r3; ADD r4 = r3 + r5 held until accepted: LD_LAT hazard cycles
    drv(1, 0, 0, 0, 0, 3, 0, 1, 0, 0); cycle("ldw_r3");
    hz = 0; done = 0;
    for (int i = 0; i < 12 && !done; i++) begin
      drv(1, 3, 1, 5, 1, 4, 0, 0, 0, 0); cycle("add_dep");
      if (obs_hz) hz++;
      if (obs_rdy) done = 1;
    end
    chk("dep.hazard_cycles", 128'(hz), 128'(LD_LAT));
    chk("dep.issued", 128'(done), 128'(1));
    idle(6);

    // ra == rb on a busy register: still one hazard per cycle
    drv(1, 0, 0, 0, 0, 9, 0, 1, 0, 0); cycle("ldw_r9");
    hz = 0; done = 0;
    for (int i = 0; i < 12 && !done; i++) begin
      drv(1, 9, 1, 9, 1, 10, 0, 0, 0, 0); cycle("same_src");
      if (obs_hz) hz++;
      if (obs_rdy) done = 1;
    end
    chk("same_src.hazard_cycles", 128'(hz), 128'(LD_LAT));
    idle(6);

    // LDW r7 then downstream stall for 4 cycles: scoreboard frozen
    drv(1, 0, 0, 0, 0, 7, 0, 1, 0, 0); cycle("ldw_r7");
    for (int i = 0; i < 4; i++) begin
      drv(1, 7, 1, 0, 0, 8, 0, 0, 1, 0); cycle("stall_hold");
    end
    hz = 0; done = 0;
    for (int i = 0; i < 12 && !done; i++) begin
      drv(1, 7, 1, 0, 0, 8, 0, 0, 0, 0); cycle("post_stall");
      if (obs_hz) hz++;
      if (obs_rdy) done = 1;
    end
    chk("post_stall.hazard_cycles", 128'(hz), 128'(LD_LAT));
    idle(6);

    // flush during the hazard cycle; scoreboard keeps counting down
    drv(1, 0, 0, 0, 0, 11, 0, 1, 0, 0); cycle("ldw_r11");
    drv(1, 11, 1, 0, 0, 12, 0, 0, 0, 1); cycle("flush_hz");
    for (int i = 0; i < LD_LAT + 1; i++) begin
      drv(1, 11, 1, 0, 0, 12, 0, 0, 0, 0); cycle("after_flush");
    end
    chk("after_flush.issued", 128'(obs_rdy), 128'(1));
    idle(6);

    // LDW r2 twice back-to-back: second reloads the counter
    drv(1, 0, 0, 0, 0, 2, 0, 1, 0, 0); cycle("ldw_r2_a");
    drv(1, 0, 0, 0, 0, 2, 0, 1, 0, 0); cycle("ldw_r2_b");
    hz = 0; done = 0;
    for (int i = 0; i < 12 && !done; i++) begin
      drv(1, 2, 0, 2, 1, 6, 0, 0, 0, 0); cycle("reload_dep");
      if (obs_hz) hz++;
      if (obs_rdy) done = 1;
    end
    chk("reload.hazard_cycles", 128'(hz), 128'(LD_LAT));
    idle(4);

    // random traffic on a small register window to make hazards frequent
    for (int n = 0; n < 400; n++) begin
      drv($urandom_range(0, 3) != 0, $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 3),
          1'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 3) == 0), 1'($urandom),
          $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
      cycle("rand");
    end

    // asynchronous reset mid-hazard
    drv(1, 0, 0, 0, 0, 5, 0, 1, 0, 0); cycle("ldw_r5");
    drv(1, 5, 1, 0, 0, 6, 0, 0, 0, 0);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    chk("async_rst.ld_hazard", 128'(ld_hazard), 128'(0));
    check_regs("async_rst");
    @(posedge clk); #1;
    reset = 1'b0;
    drv(1, 5, 1, 0, 0, 6, 0, 0, 0, 0); cycle("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
